mysystem_read_capture: RTL and testbench
========================================

Name: mysystem_read_capture

Overview:
Downstream consumer of the 1-bit read strobe that the system's Avalon-MM PIO drives out to fabric. Each rising edge of the strobe runs one req/ack transaction with an external data source and pushes the returned word into a small FIFO. The CPU drains the FIFO and reads status through an Avalon-MM slave with zero read wait states, using the same register style as the PIO.

Parameters:
DATA_W, 32, width of captured word (1..32); zero-extended onto readdata
DEPTH, 4, FIFO entries; power of two, 2..16
TIMEOUT, 255, max cycles to wait for src_ack before aborting; 1..65535

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
read_req  in  1  trigger from PIO out_port; same clock domain, level signal
src_req  out  1  request to data source
src_ack  in  1  source acknowledge; src_data valid while high
src_data  in  DATA_W  captured word
address  in  2  Avalon-MM word address
chipselect  in  1  slave select
read_n  in  1  active-low read
write_n  in  1  active-low write
writedata  in  32  write data
readdata  out  32  combinational read data
irq  out  1  high when FIFO is non-empty

Behaviour:
- Reset: FSM=IDLE; src_req=0; FIFO empty; all sticky flags 0; read_req_q=0; irq=0.
- Trigger: read_req_q <= read_req each cycle. trig = read_req & ~read_req_q. Level is not retriggered.
- FSM states IDLE, REQ, WAIT_LOW:
  - IDLE: trig -> REQ, src_req<=1 (src_req rises 1 cycle after the trig cycle).
  - REQ: if src_ack=1, push src_data into the FIFO, src_req<=0, go to WAIT_LOW. Otherwise increment the timeout counter. When count reaches TIMEOUT-1 with no ack: set timeout flag, src_req<=0, go to IDLE with no push.
  - WAIT_LOW: stay until src_ack=0, then go to IDLE.
- trig seen in REQ or WAIT_LOW: set missed flag; the trigger is discarded, not queued.
- busy = (state != IDLE).
- Push when full: word dropped, overflow flag set, FIFO unchanged.
- Pop: chipselect & ~read_n & address==0 & ~empty. readdata shows the head in that same cycle; the pointer advances at the clock edge.
- Pop when empty: readdata=0, no state change.
- Push and pop in the same cycle: both take effect and count is unchanged. This is legal even when full (pop frees the slot; no overflow).
- Register map (readdata combinational, zero wait states):
  - addr0: FIFO head zero-extended (0 if empty).
  - addr1: status. [4:0] count, [8] empty, [9] full, [10] overflow, [11] timeout, [12] missed, [13] busy, others 0.
  - addr2 write: writedata[0]/[1]/[2] = 1 clears overflow/timeout/missed. A set event in the same cycle wins over the clear. Reads of addr2 return 0.
  - addr3: reads 0, writes ignored.
- irq = ~empty, registered off the FIFO count (reset value 0).
- Reset asserted mid-transaction: src_req=0 on the next edge, FIFO contents discarded.

Decomposition:
- Shared package: register address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_CLEAR=2), status bit indices, FSM state enum.
- One sub-module: mysystem_capture_fifo (synchronous, parameterised DATA_W/DEPTH; push, pop, head, count, full, empty; first-word-fall-through).

Test Plan:
- Single capture: read_req 0->1, source acks after 3 cycles with 0xDEADBEEF. Required: src_req high 1 cycle after the edge; status count=1; irq=1; addr0 read returns 0xDEADBEEF; then count=0 and irq=0.
- Overflow: 5 captures (0x1..0x5) with DEPTH=4 and no reads. Required: full=1, overflow=1; reads return 0x1,0x2,0x3,0x4, then 0; write 0x1 to addr2 clears overflow.
- Timeout: trigger with src_ack held 0. Required: src_req drops after exactly TIMEOUT cycles; timeout=1; count=0; busy=0.
- Missed trigger: second rising edge on read_req while in REQ. Required: missed=1; exactly one push; src_req asserted only once.
- Simultaneous push/pop: FIFO full (count=4), ack and addr0 pop in the same cycle. Required: count stays 4, no overflow, head advances.
- Reset mid-op: assert reset while in REQ. Required: next cycle src_req=0, count=0, all flags 0; a subsequent trigger completes normally.

Source files
------------

// File: rtl/mysystem_read_capture_pkg.sv
// Shared definitions for the read-capture block: Avalon-MM register
// addresses, status/clear bit positions and the capture FSM state type.
package mysystem_read_capture_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CLEAR  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // Status register layout (count occupies [4:0])
    localparam int unsigned ST_COUNT_MSB = 4;
    localparam int unsigned ST_EMPTY     = 8;
    localparam int unsigned ST_FULL      = 9;
    localparam int unsigned ST_OVERFLOW  = 10;
    localparam int unsigned ST_TIMEOUT   = 11;
    localparam int unsigned ST_MISSED    = 12;
    localparam int unsigned ST_BUSY      = 13;

    // Clear register bits (write-1-to-clear)
    localparam int unsigned CLR_OVERFLOW = 0;
    localparam int unsigned CLR_TIMEOUT  = 1;
    localparam int unsigned CLR_MISSED   = 2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_LOW = 2'd2
    } cap_state_t;

endpackage

// File: rtl/mysystem_capture_fifo.sv
// First-word-fall-through synchronous FIFO for captured words.
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties FIFO)
//   push, push_data   write request and word
//   pop               read request (ignored when empty)
//   head              word at the head, valid while !empty
//   count, count_next occupancy now and after the coming edge
//   full, empty       occupancy flags
//   dropped           push rejected this cycle (full with no pop)
module mysystem_capture_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [4:0]        count,
    output logic [4:0]        count_next,
    output logic              full,
    output logic              empty,
    output logic              dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt_q;
    logic [AW:0]       cnt_d;
    logic              pop_ok;
    logic              accept;

    assign full   = (cnt_q == FULL_CNT);
    assign empty  = (cnt_q == '0);
    assign pop_ok = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then
    assign accept  = push & (~full | pop_ok);
    assign dropped = push & ~accept;
    assign head    = mem[rd_ptr];

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign count      = 5'(cnt_q);
    assign count_next = 5'(cnt_d);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mysystem_read_capture.sv
// Read-strobe capture block. A rising edge on read_req runs one src_req /
// src_ack handshake and queues the returned word; the CPU drains the queue
// and reads status through a zero-wait-state Avalon-MM slave.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   read_req                           trigger level from the PIO
//   src_req, src_ack, src_data         handshake with the data source
//   address, chipselect, read_n,
//   write_n, writedata, readdata       Avalon-MM slave (readdata combinational)
//   irq                                high while the FIFO holds data
module mysystem_read_capture
    import mysystem_read_capture_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_req,
    output logic              src_req,
    input  logic              src_ack,
    input  logic [DATA_W-1:0] src_data,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    cap_state_t        state;
    logic [15:0]       to_cnt;
    logic              read_req_q;
    logic              trig;
    logic              flag_overflow;
    logic              flag_timeout;
    logic              flag_missed;

    logic              push;
    logic              pop_en;
    logic [DATA_W-1:0] head;
    logic [4:0]        count;
    logic [4:0]        count_next;
    logic              full;
    logic              empty;
    logic              dropped;

    logic              clr_wr;
    logic              ovf_set;
    logic              to_set;
    logic              missed_set;
    logic              busy;
    logic [31:0]       data_ext;
    logic [31:0]       status;
    logic              unused_wd;

    assign unused_wd = ^writedata[31:3];

    assign trig   = read_req & ~read_req_q;
    assign busy   = (state != S_IDLE);
    assign push   = (state == S_REQ) & src_ack;
    assign pop_en = chipselect & ~read_n & (address == ADDR_DATA);
    assign clr_wr = chipselect & ~write_n & (address == ADDR_CLEAR);

    assign ovf_set    = dropped;
    assign to_set     = (state == S_REQ) & ~src_ack & (to_cnt == TO_LAST);
    assign missed_set = trig & busy;

    mysystem_capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (src_data),
        .pop        (pop_en),
        .head       (head),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty),
        .dropped    (dropped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            src_req       <= 1'b0;
            to_cnt        <= '0;
            read_req_q    <= 1'b0;
            flag_overflow <= 1'b0;
            flag_timeout  <= 1'b0;
            flag_missed   <= 1'b0;
            irq           <= 1'b0;
        end else begin
            read_req_q <= read_req;
            // Registered from the next count so irq tracks !empty without lag
            irq        <= (count_next != '0);

            case (state)
                S_IDLE: begin
                    if (trig) begin
                        state   <= S_REQ;
                        src_req <= 1'b1;
                        to_cnt  <= '0;
                    end
                end
                S_REQ: begin
                    if (src_ack) begin
                        src_req <= 1'b0;
                        state   <= S_WAIT_LOW;
                    end else if (to_cnt == TO_LAST) begin
                        src_req <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_WAIT_LOW: begin
                    if (!src_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    src_req <= 1'b0;
                end
            endcase

            // Set events take priority over a same-cycle clear
            flag_overflow <= ovf_set    | (flag_overflow & ~(clr_wr & writedata[CLR_OVERFLOW]));
            flag_timeout  <= to_set     | (flag_timeout  & ~(clr_wr & writedata[CLR_TIMEOUT]));
            flag_missed   <= missed_set | (flag_missed   & ~(clr_wr & writedata[CLR_MISSED]));
        end
    end

    always_comb begin
        data_ext = '0;
        if (!empty) begin
            data_ext[DATA_W-1:0] = head;
        end
    end

    always_comb begin
        status                 = '0;
        status[ST_COUNT_MSB:0] = count;
        status[ST_EMPTY]       = empty;
        status[ST_FULL]        = full;
        status[ST_OVERFLOW]    = flag_overflow;
        status[ST_TIMEOUT]     = flag_timeout;
        status[ST_MISSED]      = flag_missed;
        status[ST_BUSY]        = busy;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = data_ext;
            ADDR_STATUS: readdata = status;
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mysystem_read_capture.sv
// Testbench for mysystem_read_capture: directed stimulus with a read-data
// scoreboard (expected values queued at issue, compared by a monitor).
module tb_mysystem_read_capture;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              read_req;
    logic              src_req;
    logic              src_ack;
    logic [DATA_W-1:0] src_data;
    logic [1:0]        address;
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          src_req_rises = 0;
    logic        src_req_d = 1'b0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    mysystem_read_capture #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read_req   (read_req),
        .src_req    (src_req),
        .src_ack    (src_ack),
        .src_data   (src_data),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every Avalon read strobe consumes one scoreboard entry
    always @(negedge clk) begin
        logic [31:0] e;
        string       nm;
        if (chipselect && !read_n) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", readdata);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, readdata, e);
            end
        end
        if (src_req === 1'b1 && src_req_d === 1'b0) begin
            src_req_rises++;
        end
        src_req_d = src_req;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] addr, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        address    = addr;
        chipselect = 1'b1;
        read_n     = 1'b0;
        tick();
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic capture(input logic [31:0] d, input int dly);
        int n;
        read_req = 1'b1;
        tick();
        n = 0;
        while (src_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("capture_src_req", 32'(src_req), 32'd1);
        repeat (dly) tick();
        src_ack  = 1'b1;
        src_data = d;
        tick();
        src_ack = 1'b0;
        tick();
        read_req = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int rises_base;

        reset      = 1'b1;
        read_req   = 1'b0;
        src_ack    = 1'b0;
        src_data   = '0;
        address    = '0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_src_req", 32'(src_req), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        do_read(2'd1, 32'h0000_0100, "rst_status");
        do_read(2'd0, 32'h0, "rst_data_empty");
        do_read(2'd2, 32'h0, "rst_clear_reads_zero");
        do_write(2'd3, 32'hFFFF_FFFF);
        do_read(2'd3, 32'h0, "rsvd_reads_zero");
        do_read(2'd1, 32'h0000_0100, "rsvd_write_ignored");

        // Single capture, ack after 3 cycles
        read_req = 1'b1;
        check("single_src_req_before", 32'(src_req), 32'd0);
        tick();
        check("single_src_req_rise", 32'(src_req), 32'd1);
        repeat (3) tick();
        check("single_src_req_held", 32'(src_req), 32'd1);
        src_ack  = 1'b1;
        src_data = 32'hDEAD_BEEF;
        tick();
        check("single_src_req_drop", 32'(src_req), 32'd0);
        check("single_irq_set", 32'(irq), 32'd1);
        src_ack = 1'b0;
        tick();
        read_req = 1'b0;
        tick();
        do_read(2'd1, 32'h0000_0001, "single_status");
        do_read(2'd0, 32'hDEAD_BEEF, "single_data");
        check("single_irq_clear", 32'(irq), 32'd0);
        do_read(2'd1, 32'h0000_0100, "single_status_after");

        // Overflow: five captures into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            capture(32'(i), 1);
        end
        do_read(2'd1, 32'h0000_0604, "ovf_status_full");
        for (int i = 1; i <= 4; i++) begin
            do_read(2'd0, 32'(i), "ovf_data");
        end
        do_read(2'd0, 32'h0, "ovf_empty_read");
        do_read(2'd1, 32'h0000_0500, "ovf_status_drained");
        do_write(2'd2, 32'h1);
        do_read(2'd1, 32'h0000_0100, "ovf_cleared");

        // Timeout with src_ack held low
        read_req = 1'b1;
        tick();
        check("to_src_req_rise", 32'(src_req), 32'd1);
        n = 0;
        while (src_req === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check("to_src_req_cycles", 32'(n), 32'(TIMEOUT));
        read_req = 1'b0;
        tick();
        do_read(2'd1, 32'h0000_0900, "to_status");
        do_write(2'd2, 32'h2);
        do_read(2'd1, 32'h0000_0100, "to_cleared");

        // Missed trigger: second rising edge while in REQ
        rises_base = src_req_rises;
        read_req = 1'b1;
        tick();
        read_req = 1'b0;
        tick();
        read_req = 1'b1;
        tick();
        src_ack  = 1'b1;
        src_data = 32'h0000_0077;
        tick();
        src_ack = 1'b0;
        tick();
        read_req = 1'b0;
        repeat (3) tick();
        check("missed_single_src_req", 32'(src_req_rises - rises_base), 32'd1);
        do_read(2'd1, 32'h0000_1001, "missed_status");
        do_read(2'd0, 32'h0000_0077, "missed_data");
        do_read(2'd1, 32'h0000_1100, "missed_one_push");
        do_write(2'd2, 32'h4);
        do_read(2'd1, 32'h0000_0100, "missed_cleared");

        // Simultaneous push and pop while full
        for (int i = 0; i < 4; i++) begin
            capture(32'h10 + 32'(i), 1);
        end
        do_read(2'd1, 32'h0000_0204, "pp_status_full");
        read_req = 1'b1;
        tick();
        src_ack  = 1'b1;
        src_data = 32'h0000_0014;
        do_read(2'd0, 32'h0000_0010, "pp_head");
        src_ack = 1'b0;
        tick();
        read_req = 1'b0;
        tick();
        do_read(2'd1, 32'h0000_0204, "pp_status_after");
        for (int i = 1; i <= 4; i++) begin
            do_read(2'd0, 32'h10 + 32'(i), "pp_data");
        end
        do_read(2'd1, 32'h0000_0100, "pp_drained");

        // Reset while in REQ, with a queued word and the missed flag set
        capture(32'h0000_00AB, 1);
        read_req = 1'b1;
        tick();
        read_req = 1'b0;
        tick();
        read_req = 1'b1;
        tick();
        check("rstmid_in_req", 32'(src_req), 32'd1);
        reset = 1'b1;
        tick();
        check("rstmid_src_req", 32'(src_req), 32'd0);
        check("rstmid_irq", 32'(irq), 32'd0);
        reset    = 1'b0;
        read_req = 1'b0;
        tick();
        do_read(2'd1, 32'h0000_0100, "rstmid_status");
        capture(32'h0000_0055, 2);
        do_read(2'd1, 32'h0000_0001, "rstmid_recover_status");
        do_read(2'd0, 32'h0000_0055, "rstmid_recover_data");
        do_read(2'd1, 32'h0000_0100, "rstmid_recover_drained");

        repeat (2) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
